// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port data memory arbiter: ownership states
// and requester port indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam int unsigned NUM_PORTS = 2;
    localparam int unsigned PORT0     = 0;
    localparam int unsigned PORT1     = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way pick: a current owner that still requests keeps the
// grant, otherwise a lone requester wins and a tie goes to the preferred port.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 prio_i,
    input  arb_state_e           owner_i,
    output logic [NUM_PORTS-1:0] gnt_o
);

    // NOTE: gnt_o gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        gnt_o = '0;
        if (owner_i == ST_OWN0 && req_i[PORT0]) begin
            gnt_o[PORT0] = 1'b1;
        end else if (owner_i == ST_OWN1 && req_i[PORT1]) begin
            gnt_o[PORT1] = 1'b1;
        end else if (req_i[PORT0] && req_i[PORT1]) begin
            gnt_o[prio_i] = 1'b1;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares one single-port data memory between the core (port 0) and a DMA/debug
// master (port 1): round-robin fairness, bounded lock bursts, registered read data.
module data_memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  m0_req_i,
    input  logic                  m0_we_i,
    input  logic [DATA_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    input  logic                  m0_lock_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,

    input  logic                  m1_req_i,
    input  logic                  m1_we_i,
    input  logic [DATA_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    input  logic                  m1_lock_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,

    output logic                  mem_write_o,
    output logic                  mem_read_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t BURST_LAST = cnt_t'(MAX_BURST);

    arb_state_e            state_q, state_d;
    logic                  prio_q, prio_d;
    cnt_t                  cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic [NUM_PORTS-1:0]  req_v;
    logic [NUM_PORTS-1:0]  we_v;
    logic [NUM_PORTS-1:0]  gnt;
    logic                  any_gnt;
    logic                  win;
    logic                  win_we;
    logic                  win_lock;
    logic                  owner_hold;
    cnt_t                  cnt_inc;

    // Requests are masked while reset is held so nothing reaches the memory.
    assign req_v = {m1_req_i, m0_req_i} & {NUM_PORTS{reset}};
    assign we_v  = {m1_we_i, m0_we_i};

    rr_arbiter2 u_pick (
        .req_i   (req_v),
        .prio_i  (prio_q),
        .owner_i (state_q),
        .gnt_o   (gnt)
    );

    assign any_gnt    = |gnt;
    assign win        = gnt[PORT1];
    assign win_we     = win ? m1_we_i   : m0_we_i;
    assign win_lock   = win ? m1_lock_i : m0_lock_i;
    assign owner_hold = (state_q == ST_OWN0 && req_v[PORT0]) ||
                        (state_q == ST_OWN1 && req_v[PORT1]);
    assign cnt_inc    = cnt_q + cnt_t'(1);

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        if (owner_hold) begin
            cnt_d = cnt_inc;
            if (!win_lock || cnt_inc == BURST_LAST) begin
                state_d = ST_ARB;
                prio_d  = ~win;
                cnt_d   = '0;
            end
        end else begin
            // No owner, or the owner dropped its request: plain arbitration this cycle.
            state_d = ST_ARB;
            cnt_d   = '0;
            if (any_gnt) begin
                if (win_lock) begin
                    state_d = win ? ST_OWN1 : ST_OWN0;
                    cnt_d   = cnt_t'(1);
                end else begin
                    prio_d = ~win;
                end
            end
        end
    end

    always_comb begin
        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (any_gnt) begin
            mem_write_o = win_we;
            mem_read_o  = ~win_we;
            mem_addr_o  = win ? m1_addr_i  : m0_addr_i;
            mem_wdata_o = win ? m1_wdata_i : m0_wdata_i;
        end
    end

    assign rvalid_d = gnt & ~we_v;
    assign rdata0_d = rvalid_d[PORT0] ? mem_rdata_i : rdata0_q;
    assign rdata1_d = rvalid_d[PORT1] ? mem_rdata_i : rdata1_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_ARB;
            prio_q   <= 1'b0;
            cnt_q    <= '0;
            rvalid_q <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign m0_gnt_o    = gnt[PORT0];
    assign m1_gnt_o    = gnt[PORT1];
    assign m0_rvalid_o = rvalid_q[PORT0];
    assign m1_rvalid_o = rvalid_q[PORT1];
    assign m0_rdata_o  = rdata0_q;
    assign m1_rdata_o  = rdata1_q;

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter that shares the single-port data memory between two requesters: port 0 (core load/store unit) and port 1 (DMA/debug master). It issues at most one memory access per cycle and applies round-robin fairness with an optional bounded lock for short bursts. Read data is returned registered, one cycle after the grant. It sits between the requesters and the data memory instance, driving that memory's write-enable, read-enable, address and write-data inputs.

## Interface
- DATA_WIDTH, 32, width of address, write data and read data
- MAX_BURST, 4, maximum consecutive grants a locked owner may take (≥2)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req_i / m1_req_i  in  1  request; held until granted
- m0_we_i / m1_we_i  in  1  1 = write, 0 = read
- m0_addr_i / m1_addr_i  in  DATA_WIDTH  byte address, forwarded unchanged
- m0_wdata_i / m1_wdata_i  in  DATA_WIDTH  write data
- m0_lock_i / m1_lock_i  in  1  request to keep ownership after this grant
- m0_gnt_o / m1_gnt_o  out  1  access issued this cycle (combinational)
- m0_rvalid_o / m1_rvalid_o  out  1  read data valid, one cycle after a read grant
- m0_rdata_o / m1_rdata_o  out  DATA_WIDTH  registered read data
- mem_write_o  out  1  memory write enable
- mem_read_o  out  1  memory read enable
- mem_addr_o  out  DATA_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_rdata_i  in  DATA_WIDTH  memory read data, combinational from mem_addr_o

## Operation
- State register: ARB (no owner), OWN0, OWN1. Also holds prio (1 bit, preferred port), burst_cnt (clog2(MAX_BURST)+1 bits) and the per-port rvalid and rdata registers.
- ARB: a single requester wins. If both request, port prio wins. On a grant to port x: if lock_x=1, go to OWNx with burst_cnt=1; otherwise stay in ARB with prio set to the other port.
- OWNx with req_x=1: grant port x and increment burst_cnt. If lock_x=0 or the incremented burst_cnt equals MAX_BURST, go to ARB with prio set to the other port.
- OWNx with req_x=0: ownership is released in the same cycle, and the cycle is arbitrated exactly as in ARB.
- At most one gnt is high per cycle. A gnt is never asserted without the matching req.
- Memory side, when granted: mem_addr_o, mem_wdata_o and mem_write_o (=we) are muxed from the winner, and mem_read_o = ~we.
- Memory side, with no grant: all mem_* outputs are 0.
- Read grant to port x: on the next edge, mx_rdata_o <= mem_rdata_i and mx_rvalid_o = 1 for one cycle. mx_rdata_o holds its value until the next read for that port.
- Write grant: the memory commits the write at the same edge. No rvalid is produced.
- Read-after-write across ports in consecutive cycles returns the new data.

## Timing
- Reset (reset=0, asynchronous): state=ARB, prio=0, burst_cnt=0, all rvalid=0, all rdata=0. gnt and mem_* outputs are 0 because req is ignored during reset.
- Reset asserted mid-burst aborts ownership. A read granted in the cycle reset asserts produces no rvalid.
- Grant latency: 0 cycles (gnt is combinational from req and state). Read-data latency: 1 cycle. Throughput: 1 access per cycle.
- Starvation bound: a waiting requester is granted within MAX_BURST cycles.
- Requesters must keep addr/we/wdata/lock stable while req=1 and gnt=0.

## Structure
- Shared package mem_arb_pkg holds the state encoding (ARB, OWN0, OWN1) and the port index constants.
- Sub-module rr_arbiter2: combinational two-way priority pick from (req, prio, owner). It outputs a one-hot grant. The FSM, counters and response registers stay in the top module.

## Test plan
- Memory word at 0x1001_0004 = 0xDEADBEEF; m0 reads that address after reset → m0_gnt=1 in the same cycle, mem_read_o=1; next cycle m0_rvalid=1 and m0_rdata=0xDEADBEEF. All outputs are 0 while reset=0.
- Both ports request continuously with lock=0 → grant order m0, m1, m0, m1, with no idle cycles.
- MAX_BURST=4, m1 requests with lock=1 while m0 requests → m1 is granted 4 consecutive cycles, m0 in the 5th.
- m1 owns (lock=1) and drops req after 2 grants while m0 requests → m0 is granted in that same cycle and the state returns to ARB.
- m1 writes 0x12345678 to 0x1001_0008, then m0 reads 0x1001_0008 in the next cycle → m0_rdata=0x12345678, and m1_rvalid never asserts.
- reset pulsed during an m1 burst, then both ports request → m0 is granted first (prio=0), burst_cnt restarts, and no stale rvalid appears.
